// File: rtl/es_mul_sched.sv
// es_mul_sched
//   Round-robin scheduler that shares one es_naive_mul datapath among NUM_REQ
//   requesters. One operand set is accepted at a time over valid/ready. The
//   multiplier is then cleared and enabled until it raises done or the watchdog
//   expires. The product is returned together with the requester id.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for any req_valid; grants one requester round-robin
//   CLR   | one cycle with the multiplier held in reset, watchdog cleared
//   RUN   | multiplier enabled; waiting for mul_done or watchdog expiry
//   RESP  | response presented; held until rsp_ready
//
// Ports
//   clk          clock
//   rst          synchronous active-low reset
//   req_valid    per-requester request valid
//   req_ready    per-requester accept, one-hot single-cycle pulse
//   req_data     operand sets; slice r belongs to requester r
//   rsp_valid    response valid
//   rsp_ready    response accept
//   rsp_id       requester index of the response
//   rsp_data     product (zero on watchdog expiry)
//   rsp_timeout  response was produced by the watchdog
//   mul_rst      multiplier reset, active-low
//   mul_en       multiplier enable
//   mul_data_in  latched operands to the multiplier
//   mul_data_out multiplier result
//   mul_done     multiplier completion flag
module es_mul_sched #(
    parameter int DATA_WIDTH = 5,
    parameter int NUM_INPUTS = 2,
    parameter int NUM_REQ    = 4,
    parameter int MAX_CYCLES = 1028
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_REQ-1:0]                        req_valid,
    output logic [NUM_REQ-1:0]                        req_ready,
    input  logic [NUM_REQ*NUM_INPUTS*DATA_WIDTH-1:0]  req_data,
    output logic                                      rsp_valid,
    input  logic                                      rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]                rsp_id,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0]          rsp_data,
    output logic                                      rsp_timeout,
    output logic                                      mul_rst,
    output logic                                      mul_en,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0]          mul_data_in,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0]          mul_data_out,
    input  logic                                      mul_done
);

    localparam int OPW  = NUM_INPUTS * DATA_WIDTH;
    localparam int IDW  = $clog2(NUM_REQ);
    localparam int CNTW = $clog2(MAX_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [IDW-1:0]   last_grant_q, last_grant_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [OPW-1:0]   rsp_data_q, rsp_data_d;
    logic             rsp_timeout_q, rsp_timeout_d;
    logic [OPW-1:0]   mul_data_in_q, mul_data_in_d;

    logic             grant_vld;
    logic [IDW-1:0]   grant_idx;

    // Search starts just after the last served requester so every requester
    // is reached within NUM_REQ grants.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            int cand;
            cand = (int'(last_grant_q) + i) % NUM_REQ;
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = IDW'(cand);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_grant_d  = last_grant_q;
        rsp_id_d      = rsp_id_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;
        mul_data_in_d = mul_data_in_q;
        req_ready     = '0;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    req_ready[grant_idx] = 1'b1;
                    mul_data_in_d        = req_data[grant_idx*OPW +: OPW];
                    rsp_id_d             = grant_idx;
                    state_d              = CLR;
                end
            end
            CLR: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                // done has priority over a watchdog expiry in the same cycle
                if (mul_done) begin
                    rsp_data_d    = mul_data_out;
                    rsp_timeout_d = 1'b0;
                    state_d       = RESP;
                end else if (cnt_q == CNTW'(MAX_CYCLES - 1)) begin
                    rsp_data_d    = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    last_grant_d = rsp_id_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            last_grant_q  <= IDW'(NUM_REQ - 1);
            rsp_id_q      <= '0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
            mul_data_in_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_grant_q  <= last_grant_d;
            rsp_id_q      <= rsp_id_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
            mul_data_in_q <= mul_data_in_d;
        end
    end

    assign rsp_valid   = (state_q == RESP);
    assign rsp_id      = rsp_id_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_timeout = rsp_timeout_q;
    assign mul_en      = (state_q == RUN);
    assign mul_data_in = mul_data_in_q;
    // The multiplier follows the scheduler reset directly, so it is cleared
    // while rst is low even though the state register only updates on the edge.
    assign mul_rst     = rst & (state_q != CLR);

endmodule

// File: tb/tb_es_mul_sched.sv
// Testbench for es_mul_sched with a stub multiplier that raises done on its
// stub_n-th enabled cycle (never when stub_n is 0) and drives a fixed result.
module tb_es_mul_sched;

    localparam int DW   = 5;
    localparam int NI   = 2;
    localparam int NR   = 4;
    localparam int MAXC = 1028;
    localparam int OPW  = DW * NI;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [NR-1:0]      req_valid = '0;
    logic [NR-1:0]      req_ready;
    logic [NR*OPW-1:0]  req_data = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b1;
    logic [1:0]         rsp_id;
    logic [OPW-1:0]     rsp_data;
    logic               rsp_timeout;
    logic               mul_rst;
    logic               mul_en;
    logic [OPW-1:0]     mul_data_in;
    logic [OPW-1:0]     mul_data_out;
    logic               mul_done;

    es_mul_sched #(
        .DATA_WIDTH(DW), .NUM_INPUTS(NI), .NUM_REQ(NR), .MAX_CYCLES(MAXC)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .mul_rst(mul_rst), .mul_en(mul_en), .mul_data_in(mul_data_in),
        .mul_data_out(mul_data_out), .mul_done(mul_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // stub multiplier
    int             stub_n = 10;
    logic [OPW-1:0] stub_res = 10'h155;
    int             en_cnt = 0;
    always @(posedge clk) begin
        if (!mul_rst)    en_cnt <= 0;
        else if (mul_en) en_cnt <= en_cnt + 1;
    end
    assign mul_done     = mul_en && (stub_n != 0) && (en_cnt == stub_n - 1);
    assign mul_data_out = stub_res;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic [1:0]     id;
        logic [OPW-1:0] data;
        logic           to;
    } exp_t;

    exp_t           sb[$];
    logic [OPW-1:0] exp_ops = '0;
    int             n_acc = 0;
    int             n_rsp = 0;

    // monitor: scoreboard push on accept, pop on response handshake
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            n_acc = 0;
            n_rsp = 0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                n_rsp++;
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 32'(sb.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                    chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
                end
            end
            if (|req_ready) begin
                exp_t e;
                int g;
                g = 0;
                for (int r = 0; r < NR; r++) if (req_ready[r]) g = r;
                chk("rdy_onehot", 32'($countones(req_ready)), 32'd1);
                chk("rdy_valid", 32'(req_valid[g]), 32'd1);
                e.id   = 2'(g);
                e.data = (stub_n == 0) ? '0 : stub_res;
                e.to   = (stub_n == 0);
                sb.push_back(e);
                exp_ops = req_data[g*OPW +: OPW];
                n_acc++;
            end
            if (!mul_rst) chk("mul_data_in", 32'(mul_data_in), 32'(exp_ops));
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic wait_ready(output int id);
        bit ok;
        ok = 1'b0;
        id = -1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (|req_ready) begin
                ok = 1'b1;
                for (int r = 0; r < NR; r++) if (req_ready[r]) id = r;
            end
        end
        chk("wait_ready_bound", 32'(ok), 32'd1);
    endtask

    task automatic wait_rsp(input int lim, output int en_cycles);
        bit ok;
        ok = 1'b0;
        en_cycles = 0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clk);
            if (rsp_valid) ok = 1'b1;
            else if (mul_en) en_cycles++;
        end
        chk("wait_rsp_bound", 32'(ok), 32'd1);
    endtask

    task automatic rand_data();
        for (int r = 0; r < NR; r++) req_data[r*OPW +: OPW] = OPW'($urandom);
    endtask

    initial begin
        int id, t_a, en, g;
        int exp_g[9];

        // reset values
        @(negedge clk);
        chk("rst_mul_rst", 32'(mul_rst), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_mul_en", 32'(mul_en), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_timeout", 32'(rsp_timeout), 32'd0);
        chk("rst_mul_data_in", 32'(mul_data_in), 32'd0);
        chk("rst_mul_rst_rel", 32'(mul_rst), 32'd1);

        // single request latency
        rand_data();
        req_data[0 +: OPW] = {5'd16, 5'd8};
        stub_n = 10; stub_res = 10'h155; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 4'b0001;
        wait_ready(id);
        t_a = cyc;
        chk("t1_grant", 32'(id), 32'd0);
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(100, en);
        chk("t1_latency", 32'(cyc - t_a), 32'd12);
        chk("t1_en_cycles", 32'(en), 32'd10);
        chk("t1_rsp_id", 32'(rsp_id), 32'd0);
        chk("t1_rsp_data", 32'(rsp_data), 32'h155);
        chk("t1_timeout", 32'(rsp_timeout), 32'd0);

        // fairness
        do_reset();
        rand_data();
        stub_n = 2; stub_res = 10'h0F3;
        exp_g = '{0, 1, 2, 3, 0, 1, 2, 3, 2};
        req_valid = 4'b1111;
        for (int k = 0; k < 9; k++) begin
            wait_ready(g);
            chk("t2_grant", 32'(g), 32'(exp_g[k]));
            if (k == 7) begin
                @(posedge clk); #1;
                req_valid = 4'b0100;
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(100, en);

        // backpressure
        do_reset();
        rand_data();
        stub_n = 3; stub_res = 10'h2C7; rsp_ready = 1'b0;
        req_valid = 4'b0010;
        wait_ready(id);
        chk("t3_grant", 32'(id), 32'd1);
        @(posedge clk); #1;
        req_valid = 4'b1101;
        wait_rsp(100, en);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("t3_valid", 32'(rsp_valid), 32'd1);
            chk("t3_id", 32'(rsp_id), 32'd1);
            chk("t3_data", 32'(rsp_data), 32'h2C7);
            chk("t3_req_ready", 32'(req_ready), 32'd0);
            chk("t3_mul_en", 32'(mul_en), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t3_rsp_drop", 32'(rsp_valid), 32'd0);
        chk("t3_next_grant", 32'(req_ready), 32'b0100);
        @(posedge clk); #1;
        req_valid = '0;

        // watchdog timeout
        do_reset();
        rand_data();
        stub_n = 0; stub_res = 10'h3FF;
        req_valid = 4'b1000;
        wait_ready(id);
        chk("t4_grant", 32'(id), 32'd3);
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(1200, en);
        chk("t4_en_cycles", 32'(en), 32'(MAXC));
        chk("t4_timeout", 32'(rsp_timeout), 32'd1);
        chk("t4_data", 32'(rsp_data), 32'd0);

        // done on the last watchdog cycle
        @(posedge clk); #1;
        stub_n = MAXC; stub_res = 10'h2AB;
        req_valid = 4'b0100;
        wait_ready(id);
        chk("t5_grant", 32'(id), 32'd2);
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(1200, en);
        chk("t5_en_cycles", 32'(en), 32'(MAXC));
        chk("t5_timeout", 32'(rsp_timeout), 32'd0);
        chk("t5_data", 32'(rsp_data), 32'h2AB);

        // reset in the middle of RUN
        do_reset();
        rand_data();
        stub_n = 20; stub_res = 10'h0AA;
        req_valid = 4'b1111;
        wait_ready(id);
        chk("t6_grant0", 32'(id), 32'd0);
        en = 0;
        for (int i = 0; i < 50 && en < 4; i++) begin
            @(negedge clk);
            if (mul_en) en++;
        end
        chk("t6_en_reached", 32'(en), 32'd4);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;
        @(negedge clk);
        chk("t6_mul_rst_low", 32'(mul_rst), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t6_mul_en", 32'(mul_en), 32'd0);
        chk("t6_req_ready", 32'(req_ready), 32'd0);
        chk("t6_rsp_id", 32'(rsp_id), 32'd0);
        chk("t6_rsp_data", 32'(rsp_data), 32'd0);
        chk("t6_mul_data_in", 32'(mul_data_in), 32'd0);
        @(posedge clk); #1;
        req_valid = 4'b1111;
        wait_ready(id);
        chk("t6_grant_after", 32'(id), 32'd0);
        @(posedge clk); #1;
        req_valid = '0;
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        repeat (40) @(posedge clk);
        chk("t6_sb_empty", 32'(sb.size()), 32'd0);
        chk("t6_rsp_count", 32'(n_rsp), 32'(n_acc));
        chk("t6_rsp_count_val", 32'(n_rsp), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
